branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_cache.sv | 66 ++++++
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - counter encodings, miss-initialisation values and saturating update
// Shared by branch_predictor; no ports.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] WT  = 2'b10;  // weak taken
  localparam logic [1:0] ST  = 2'b11;  // strong taken

  // Values a fresh entry starts from when a check misses.
  localparam logic [1:0] MISS_INIT_TAKEN     = WT;
  localparam logic [1:0] MISS_INIT_NOT_TAKEN = WNT;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == ST) ? ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_cache.sv
// rtl/bp_cache.sv - direct-mapped tagged cache, two combinational read ports, one write port
// Ports: clk_i, rst_i (async, active-high, invalidates all lines),
//        rd_addr{0,1}_i -> rd_hit{0,1}_o / rd_data{0,1}_o,
//        wr_en_i / wr_addr_i / wr_data_i (written on the rising edge).
// Index is addr[log2(LINES)+1:2]; the bits above it form the tag.
module bp_cache #(
  parameter int AWIDTH = 32,
  parameter int LINES  = 128,
  parameter int DWIDTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] rd_addr0_i,
  output logic              rd_hit0_o,
  output logic [DWIDTH-1:0] rd_data0_o,
  input  logic [AWIDTH-1:0] rd_addr1_i,
  output logic              rd_hit1_o,
  output logic [DWIDTH-1:0] rd_data1_o,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AWIDTH - IW - 2;

  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [DWIDTH-1:0] data_q [LINES];

  logic [IW-1:0] idx0, idx1, widx;
  logic [TW-1:0] tag0, tag1, wtag;

  // PCs are word aligned, so the two low bits never select anything.
  logic unused_low_bits;
  assign unused_low_bits = ^{rd_addr0_i[1:0], rd_addr1_i[1:0], wr_addr_i[1:0]};

  assign idx0 = rd_addr0_i[IW+1:2];
  assign idx1 = rd_addr1_i[IW+1:2];
  assign widx = wr_addr_i[IW+1:2];
  assign tag0 = rd_addr0_i[AWIDTH-1:IW+2];
  assign tag1 = rd_addr1_i[AWIDTH-1:IW+2];
  assign wtag = wr_addr_i[AWIDTH-1:IW+2];

  assign rd_hit0_o  = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign rd_data0_o = data_q[idx0];
  assign rd_hit1_o  = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign rd_data1_o = data_q[idx1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is ignored until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating-counter branch predictor with pending-update forwarding
// Ports: clk, reset (async, active-low), guess_pc/is_br_guess -> guess (combinational),
//        check_pc/is_br_check/br_taken_check (resolved branch),
//        num_branches / num_mispredicts (32-bit wrapping statistics).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int LINES    = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] guess_pc,
  input  logic                is_br_guess,
  output logic                guess,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  output logic [31:0]         num_branches,
  output logic [31:0]         num_mispredicts
);

  logic                pend_valid_q, pend_valid_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]          pend_ctr_q, pend_ctr_d;
  logic [31:0]         num_branches_q, num_branches_d;
  logic [31:0]         num_mispredicts_q, num_mispredicts_d;

  logic       g_cache_hit, c_cache_hit;
  logic [1:0] g_cache_ctr, c_cache_ctr;
  logic       g_fwd, c_fwd;
  logic       g_hit, c_hit;
  logic [1:0] g_eff, c_eff;
  logic       c_pred;

  // The pending register is written to the cache on the edge after capture.
  bp_cache #(
    .AWIDTH(PC_WIDTH),
    .LINES (LINES),
    .DWIDTH(2)
  ) u_cache (
    .clk_i     (clk),
    .rst_i     (~reset),
    .rd_addr0_i(guess_pc),
    .rd_hit0_o (g_cache_hit),
    .rd_data0_o(g_cache_ctr),
    .rd_addr1_i(check_pc),
    .rd_hit1_o (c_cache_hit),
    .rd_data1_o(c_cache_ctr),
    .wr_en_i   (pend_valid_q),
    .wr_addr_i (pend_pc_q),
    .wr_data_i (pend_ctr_q)
  );

  // A pending update for the exact same PC is newer than the cache contents,
  // so it wins; it also counts as a hit because it is about to be installed.
  assign g_fwd = pend_valid_q && (pend_pc_q == guess_pc);
  assign c_fwd = pend_valid_q && (pend_pc_q == check_pc);
  assign g_hit = g_fwd || g_cache_hit;
  assign c_hit = c_fwd || c_cache_hit;
  assign g_eff = g_fwd ? pend_ctr_q : g_cache_ctr;
  assign c_eff = c_fwd ? pend_ctr_q : c_cache_ctr;

  assign guess  = is_br_guess && g_hit && g_eff[1];
  assign c_pred = c_hit && c_eff[1];

  always_comb begin
    pend_valid_d      = is_br_check;
    pend_pc_d         = pend_pc_q;
    pend_ctr_d        = pend_ctr_q;
    num_branches_d    = num_branches_q;
    num_mispredicts_d = num_mispredicts_q;
    if (is_br_check) begin
      pend_pc_d      = check_pc;
      num_branches_d = num_branches_q + 32'd1;
      if (c_pred != br_taken_check) begin
        num_mispredicts_d = num_mispredicts_q + 32'd1;
      end
      if (c_hit) begin
        pend_ctr_d = br_taken_check ? sat_inc(c_eff) : sat_dec(c_eff);
      end else begin
        pend_ctr_d = br_taken_check ? MISS_INIT_TAKEN : MISS_INIT_NOT_TAKEN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q      <= 1'b0;
      pend_pc_q         <= '0;
      pend_ctr_q        <= SNT;
      num_branches_q    <= '0;
      num_mispredicts_q <= '0;
    end else begin
      pend_valid_q      <= pend_valid_d;
      pend_pc_q         <= pend_pc_d;
      pend_ctr_q        <= pend_ctr_d;
      num_branches_q    <= num_branches_d;
      num_mispredicts_q <= num_mispredicts_d;
    end
  end

  assign num_branches    = num_branches_q;
  assign num_mispredicts = num_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a table model
module tb_branch_predictor;

  localparam int PW = 32;
  localparam int LN = 16;
  localparam int IW = $clog2(LN);

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] guess_pc;
  logic          is_br_guess;
  logic          guess;
  logic [PW-1:0] check_pc;
  logic          is_br_check;
  logic          br_taken_check;
  logic [31:0]   num_branches;
  logic [31:0]   num_mispredicts;

  branch_predictor #(.PC_WIDTH(PW), .LINES(LN)) dut (
    .clk            (clk),
    .reset          (reset),
    .guess_pc       (guess_pc),
    .is_br_guess    (is_br_guess),
    .guess          (guess),
    .check_pc       (check_pc),
    .is_br_check    (is_br_check),
    .br_taken_check (br_taken_check),
    .num_branches   (num_branches),
    .num_mispredicts(num_mispredicts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: committed table of whole PCs per line plus the one pending update.
  bit            m_v  [LN];
  logic [PW-1:0] m_pc [LN];
  int            m_c  [LN];
  bit            p_v;
  logic [PW-1:0] p_pc;
  int            p_c;
  logic [31:0]   m_nb, m_nm;

  function automatic int line_of(input logic [PW-1:0] pc);
    return int'((pc >> 2) % LN);
  endfunction

  function automatic void m_look(input logic [PW-1:0] pc, output bit hit, output int c);
    int i;
    i = line_of(pc);
    if (p_v && p_pc == pc) begin
      hit = 1; c = p_c;
    end else if (m_v[i] && (m_pc[i] >> (IW + 2)) == (pc >> (IW + 2))) begin
      hit = 1; c = m_c[i];
    end else begin
      hit = 0; c = 0;
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < LN; i++) m_v[i] = 0;
    p_v = 0; m_nb = 0; m_nm = 0;
  endfunction

  task automatic m_edge(input bit cv, input logic [PW-1:0] cpc, input bit tk);
    bit h;
    int c, nx, i;
    h = 0; c = 0; nx = 0;
    if (cv) begin
      m_look(cpc, h, c);
      if (!h) nx = tk ? 2 : 1;
      else if (tk) nx = (c + 1 > 3) ? 3 : c + 1;
      else nx = (c - 1 < 0) ? 0 : c - 1;
    end
    if (p_v) begin
      i = line_of(p_pc);
      m_v[i] = 1; m_pc[i] = p_pc; m_c[i] = p_c;
    end
    if (cv) begin
      p_v = 1; p_pc = cpc; p_c = nx;
      m_nb = m_nb + 32'd1;
      if ((h && c >= 2) != tk) m_nm = m_nm + 32'd1;
    end else begin
      p_v = 0;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input bit gv, input logic [PW-1:0] gpc, input bit cv,
                       input logic [PW-1:0] cpc, input bit tk, input int exp_g = -1);
    bit h;
    int c;
    is_br_guess = gv; guess_pc = gpc;
    is_br_check = cv; check_pc = cpc; br_taken_check = tk;
    #4;
    m_look(gpc, h, c);
    check_eq("guess", {31'd0, guess}, {31'd0, (gv && h && c >= 2)});
    if (exp_g >= 0) check_eq("guess_directed", {31'd0, guess}, exp_g);
    @(posedge clk);
    m_edge(cv, cpc, tk);
    #1;
    check_eq("num_branches", num_branches, m_nb);
    check_eq("num_mispredicts", num_mispredicts, m_nm);
  endtask

  task automatic check_pend(input int exp_c);
    check_eq("pend_valid", {31'd0, dut.pend_valid_q}, 32'd1);
    check_eq("pend_ctr", {30'd0, dut.pend_ctr_q}, exp_c);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_clear();
    check_eq("rst_guess", {31'd0, guess}, 32'd0);
    check_eq("rst_nbr", num_branches, 32'd0);
    check_eq("rst_nmis", num_mispredicts, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] base, alias_pc, pool_pc;
    base = 32'h40;
    alias_pc = base + 4 * LN;
    reset = 1'b0; guess_pc = '0; is_br_guess = 0;
    check_pc = '0; is_br_check = 0; br_taken_check = 0;
    m_clear();
    @(posedge clk); #1;
    do_reset();

    // Empty predictor guesses not-taken.
    cycle(1, base, 0, 0, 0, 0);

    // Three taken checks chain 10, 11, 11.
    cycle(1, base, 1, base, 1); check_pend(2);
    cycle(1, base, 1, base, 1); check_pend(3);
    cycle(1, base, 1, base, 1); check_pend(3);
    cycle(1, base, 0, 0, 0, 1);
    check_eq("nbr_after3", num_branches, 32'd3);
    check_eq("nmis_after3", num_mispredicts, 32'd1);

    // Two not-taken from 11 -> 01, two mispredicts.
    cycle(0, 0, 1, base, 0); check_pend(2);
    cycle(0, 0, 1, base, 0); check_pend(1);
    cycle(1, base, 0, 0, 0, 0);
    check_eq("nmis_after_nt", num_mispredicts, 32'd3);

    // Forwarded guess before the write lands.
    cycle(0, 0, 1, base, 1); check_pend(2);
    cycle(1, base, 0, 0, 0, 1);

    // Train to 11, then an alias miss evicts the line.
    cycle(0, 0, 1, base, 1);
    cycle(0, 0, 1, base, 1); check_pend(3);
    cycle(1, base, 0, 0, 0, 1);
    cycle(0, 0, 1, alias_pc, 1); check_pend(2);
    cycle(1, alias_pc, 0, 0, 0, 1);
    cycle(1, base, 0, 0, 0, 0);

    // Reset with an update pending: nothing may be written.
    cycle(0, 0, 1, base + 4, 1); check_pend(2);
    do_reset();
    cycle(1, base + 4, 0, 0, 0, 0);
    cycle(1, alias_pc, 0, 0, 0, 0);
    cycle(1, base, 0, 0, 0, 0);

    // Randomized traffic over a small, heavily aliased PC pool.
    for (int n = 0; n < 800; n++) begin
      bit cv, gv, tk;
      logic [PW-1:0] gpc;
      pool_pc = base + 4 * $urandom_range(0, 3) + (($urandom_range(0, 1) == 1) ? 4 * LN : 0);
      gpc = base + 4 * $urandom_range(0, 3) + (($urandom_range(0, 1) == 1) ? 4 * LN : 0);
      if ($urandom_range(0, 2) == 0 && p_v) gpc = p_pc;
      cv = ($urandom_range(0, 3) != 0);
      gv = ($urandom_range(0, 4) != 0);
      tk = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(gv, gpc, cv, pool_pc, tk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
